// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: active-low gfedcba glyphs,
// the blanked pattern and a width helper for index and counter registers.
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_PATTERNS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int seg_clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_PATTERNS[nib];

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment scanner with PWM brightness, blank guard and
// frame-synchronous double buffering. Define SEG_SCAN_LZB_EN for leading-zero blanking.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int DIGITS    = 8,
    parameter int DWELL_CYC = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [4*DIGITS-1:0]          data,
    input  logic [DIGITS-1:0]            dp,
    input  logic                         load,
    input  logic [3:0]                   bright,
    output logic [DIGITS-1:0]            an,
    output logic [seg_clog2(DIGITS)-1:0] sel,
    output logic [6:0]                   seg,
    output logic                         seg_dp,
    output logic                         frame_done
);

    localparam int SEL_W    = seg_clog2(DIGITS);
    localparam int CNT_W    = seg_clog2(DWELL_CYC);
    localparam int SLOT_CYC = (DWELL_CYC - BLANK_CYC) / 16;
    localparam int SUB_W    = seg_clog2(SLOT_CYC);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [SEL_W-1:0] IDX_LAST  = SEL_W'(DIGITS - 1);
    localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(SLOT_CYC - 1);

    logic [CNT_W-1:0]    cnt;
    logic [SEL_W-1:0]    idx;
    logic [SUB_W-1:0]    sub;
    logic [3:0]          slot;
    logic [3:0]          bri_q;
    logic [4*DIGITS-1:0] pend_data, act_data, act_data_nx;
    logic [DIGITS-1:0]   pend_dp, act_dp, act_dp_nx;
    logic [DIGITS-1:0]   lzb_mask;
    logic                dwell_end, frame_end;
    logic [3:0]          bri_eff;
    logic [3:0]          cur_nib;
    logic                cur_dp, cur_blank, lit;
    logic [6:0]          cur_seg;
    logic [DIGITS-1:0]   an_nx;

    assign dwell_end   = (cnt == CNT_LAST);
    assign frame_end   = dwell_end && (idx == IDX_LAST);
    // bri_q only takes the new sample on this edge, so the cnt==0 cycle looks at bright directly.
    assign bri_eff     = (cnt == '0) ? bright : bri_q;
    assign act_data_nx = load ? data : pend_data;
    assign act_dp_nx   = load ? dp   : pend_dp;

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == SEL_W'(i)) begin
                cur_nib   = act_data[4*i +: 4];
                cur_dp    = act_dp[i];
                cur_blank = lzb_mask[i];
            end
        end
    end

    assign lit = (cnt >= CNT_BLANK) && (slot < bri_eff) && !cur_blank;

    always_comb begin
        an_nx = '1;
        for (int i = 0; i < DIGITS; i++) begin
            an_nx[i] = !(lit && (idx == SEL_W'(i)));
        end
    end

    seg_hex_decode u_dec (
        .nib (cur_nib),
        .seg (cur_seg)
    );

    // Scan counters; the slot counter replaces a divide of (cnt - BLANK_CYC) by SLOT_CYC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            idx   <= '0;
            sub   <= '0;
            slot  <= '0;
            bri_q <= '0;
        end else begin
            if (cnt == '0) bri_q <= bright;
            if (dwell_end) begin
                cnt  <= '0;
                sub  <= '0;
                slot <= '0;
                idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
                if (cnt >= CNT_BLANK) begin
                    if (sub == SUB_LAST) begin
                        sub  <= '0;
                        slot <= slot + 1'b1;
                    end else begin
                        sub <= sub + 1'b1;
                    end
                end
            end
        end
    end

    // Double buffer: a load on the boundary cycle bypasses pending straight into active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_data <= '0;
            pend_dp   <= '0;
            act_data  <= '0;
            act_dp    <= '0;
        end else begin
            if (load) begin
                pend_data <= data;
                pend_dp   <= dp;
            end
            if (frame_end) begin
                act_data <= act_data_nx;
                act_dp   <= act_dp_nx;
            end
        end
    end

`ifdef SEG_SCAN_LZB_EN
    function automatic logic [DIGITS-1:0] lzb_calc(input logic [4*DIGITS-1:0] d,
                                                   input logic [DIGITS-1:0]   p);
        logic run;
        run      = 1'b1;
        lzb_calc = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            run         = run && (d[4*i +: 4] == 4'h0) && !p[i];
            lzb_calc[i] = run;
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         lzb_mask <= lzb_calc('0, '0);
        else if (frame_end) lzb_mask <= lzb_calc(act_data_nx, act_dp_nx);
    end
`else
    assign lzb_mask = '0;
`endif

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= '1;
            seg        <= SEG_OFF;
            seg_dp     <= 1'b1;
            sel        <= '0;
            frame_done <= 1'b0;
        end else begin
            an         <= an_nx;
            seg        <= lit ? cur_seg : SEG_OFF;
            seg_dp     <= !(lit && cur_dp);
            sel        <= idx;
            frame_done <= frame_end;
        end
    end

endmodule
